// File: rtl/regfile_access_ctrl.sv
// Sole master of an 8 x 16-bit register file: accepts single writes and 1-8 beat
// wrapping read bursts, sequences the register-file strobes and returns one response per access.
module regfile_access_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    output logic [DATA_W-1:0] WrData,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RdData
);

    typedef enum logic [2:0] {IDLE, WR, RD, CAPT, RESP, ERR} state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        beats_left;
    logic              accept;
    logic              illegal;
    logic [ADDR_W-1:0] addr_next;

    assign accept    = req_valid && req_ready;
    assign illegal   = 32'(req_addr) >= NUM_REGS;
    assign addr_next = (Address == ADDR_W'(NUM_REGS - 1)) ? '0 : Address + ADDR_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal)        state_next = ERR;
                    else if (req_write) state_next = WR;
                    else                state_next = RD;
                end
            end
            WR:   state_next = RESP;
            ERR:  state_next = RESP;
            RD:   state_next = CAPT;
            CAPT: state_next = RESP;
            RESP: begin
                if (resp_ready) state_next = resp_last ? IDLE : RD;
            end
            default: state_next = IDLE;
        endcase
    end

    // req_ready is gated by RST so it reads low for the whole reset pulse.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        WrEn       = 1'b0;
        RdEn       = 1'b0;
        case (state)
            IDLE:    req_ready  = !RST;
            WR:      WrEn       = 1'b1;
            RD:      RdEn       = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Address doubles as the burst's current address; it only moves on legal accepts and beat handshakes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beats_left <= '0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
            resp_err   <= 1'b0;
            Address    <= '0;
            WrData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_err <= 1'b0;
                        if (!illegal) begin
                            Address    <= req_addr;
                            beats_left <= req_write ? 3'd0 : req_len;
                            if (req_write) WrData <= req_wdata;
                        end
                    end
                end
                WR: begin
                    resp_data <= '0;
                    resp_last <= 1'b1;
                end
                ERR: begin
                    resp_data <= '0;
                    resp_last <= 1'b1;
                    resp_err  <= 1'b1;
                end
                CAPT: begin
                    resp_data <= RdData;
                    resp_last <= (beats_left == 3'd0);
                end
                RESP: begin
                    if (resp_ready && !resp_last) begin
                        Address    <= addr_next;
                        beats_left <= beats_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: directed scenarios plus randomized
// transactions checked against an array model of the register file contents.
module tb_regfile_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [2:0]  req_len = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic [15:0] WrData;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [15:0] RdData = '0;

    int assertions = 0;
    int failures   = 0;
    int wr_pulses  = 0;
    int rd_pulses  = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;

    logic [15:0] rf      [8];
    logic [15:0] ref_mem [8];

    regfile_access_ctrl #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData)
    );

    always #5 CLK = ~CLK;

    // Register file with registered read port
    always @(posedge CLK) begin
        if (WrEn) rf[Address[2:0]] <= WrData;
        if (RdEn) RdData <= rf[Address[2:0]];
    end

    // Strobe invariants observed every cycle
    always @(negedge CLK) begin
        if (!RST && (WrEn || RdEn)) begin
            assertions++;
            if ((WrEn && RdEn) || Address[3] || (WrEn && prev_wr) || (RdEn && prev_rd)) begin
                failures++;
                $display("FAIL strobe_invariant: WrEn=%b RdEn=%b Address=%0d prev_wr=%b prev_rd=%b, required exclusive one-cycle strobes with Address<8",
                         WrEn, RdEn, Address, prev_wr, prev_rd);
            end
            if (WrEn) wr_pulses++;
            if (RdEn) rd_pulses++;
        end
        prev_wr = WrEn && !RST;
        prev_rd = RdEn && !RST;
    end

    task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                           input logic [2:0] len, input int stall_beat, input int stall_cycles);
        logic        ill;
        int          nbeats;
        int          n;
        int          rd0;
        int          wr0;
        logic [15:0] exp_d;
        logic [15:0] hold;
        ill    = (addr >= 4'd8);
        nbeats = (ill || wr) ? 1 : int'(len) + 1;
        rd0    = rd_pulses;
        wr0    = wr_pulses;

        @(negedge CLK);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_len = len;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge CLK); n++; end
        assertions++;
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 20 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        req_valid  = 1'b0;
        resp_ready = (stall_beat == 0) ? 1'b0 : 1'b1;
        if (wr && !ill) ref_mem[addr[2:0]] = data;

        // Cycle after acceptance
        @(negedge CLK);
        assertions++;
        if (ill) begin
            if (WrEn !== 1'b0 || RdEn !== 1'b0 || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL err_cycle1: WrEn=%b RdEn=%b resp_valid=%b, required 0 0 0", WrEn, RdEn, resp_valid);
            end
        end else if (wr) begin
            if (WrEn !== 1'b1 || RdEn !== 1'b0 || Address !== addr || WrData !== data || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL wr_strobe: WrEn=%b RdEn=%b Address=%0d WrData=%h resp_valid=%b, required 1 0 %0d %h 0",
                         WrEn, RdEn, Address, WrData, resp_valid, addr, data);
            end
        end else begin
            if (RdEn !== 1'b1 || WrEn !== 1'b0 || Address !== addr || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_strobe: RdEn=%b WrEn=%b Address=%0d resp_valid=%b, required 1 0 %0d 0",
                         RdEn, WrEn, Address, resp_valid, addr);
            end
            @(negedge CLK);
            assertions++;
            if (RdEn !== 1'b0 || WrEn !== 1'b0 || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL capt_cycle: RdEn=%b WrEn=%b resp_valid=%b, required 0 0 0", RdEn, WrEn, resp_valid);
            end
        end

        for (int b = 0; b < nbeats; b++) begin
            @(negedge CLK);
            n = 0;
            while (!resp_valid && n < 30) begin @(negedge CLK); n++; end
            assertions++;
            if (!resp_valid) begin
                failures++;
                $display("FAIL resp_timeout: beat %0d resp_valid=%b, required 1 within 30 cycles", b, resp_valid);
                resp_ready = 1'b1;
                return;
            end
            assertions++;
            if (b == 0 && n != 0) begin
                failures++;
                $display("FAIL resp_latency: first beat late by %0d cycles, required 0", n);
            end
            exp_d = (wr || ill) ? 16'h0000 : ref_mem[(int'(addr) + b) % 8];
            assertions++;
            if (resp_data !== exp_d || resp_last !== (b == nbeats - 1) || resp_err !== ill) begin
                failures++;
                $display("FAIL resp_beat: beat %0d data=%h last=%b err=%b, required %h %b %b",
                         b, resp_data, resp_last, resp_err, exp_d, (b == nbeats - 1), ill);
            end
            if (b == stall_beat) begin
                hold = resp_data;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge CLK);
                    assertions++;
                    if (resp_valid !== 1'b1 || resp_data !== hold || RdEn !== 1'b0 || WrEn !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold: resp_valid=%b data=%h RdEn=%b WrEn=%b, required 1 %h 0 0",
                                 resp_valid, resp_data, RdEn, WrEn, hold);
                    end
                end
                resp_ready = 1'b1;
            end
            @(posedge CLK); #1;
            resp_ready = (b + 1 == stall_beat) ? 1'b0 : 1'b1;
        end

        @(negedge CLK);
        assertions++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
        end
        assertions++;
        if (rd_pulses - rd0 != ((wr || ill) ? 0 : nbeats) || wr_pulses - wr0 != ((wr && !ill) ? 1 : 0)) begin
            failures++;
            $display("FAIL strobe_count: rd=%0d wr=%0d, required rd=%0d wr=%0d", rd_pulses - rd0, wr_pulses - wr0,
                     (wr || ill) ? 0 : nbeats, (wr && !ill) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        assertions++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 16'h0 || resp_last !== 1'b0 ||
            resp_err !== 1'b0 || WrEn !== 1'b0 || RdEn !== 1'b0 || Address !== 4'h0 || WrData !== 16'h0) begin
            failures++;
            $display("FAIL reset_values: ready=%b valid=%b data=%h last=%b err=%b WrEn=%b RdEn=%b Addr=%h WrData=%h, required all 0",
                     req_ready, resp_valid, resp_data, resp_last, resp_err, WrEn, RdEn, Address, WrData);
        end
        RST = 1'b0;
        @(negedge CLK);
        assertions++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 4'd3, 16'hA5A5, 3'd5, -1, 0);
    endtask

    task automatic test_single_read();
        run_txn(1'b1, 4'd5, 16'h1234, 3'd0, -1, 0);
        run_txn(1'b0, 4'd5, 16'h0000, 3'd0, -1, 0);
    endtask

    task automatic test_wrap_burst();
        for (int i = 0; i < 8; i++) run_txn(1'b1, 4'(i), 16'h1000 + 16'(i), 3'd0, -1, 0);
        run_txn(1'b0, 4'd6, 16'h0000, 3'd3, -1, 0);
    endtask

    task automatic test_illegal();
        run_txn(1'b0, 4'd9, 16'h0000, 3'd5, -1, 0);
        run_txn(1'b1, 4'd12, 16'hDEAD, 3'd0, -1, 0);
        run_txn(1'b0, 4'd15, 16'h0000, 3'd0, 0, 2);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 4'd2, 16'h0000, 3'd7, 2, 5);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0; req_len = 3'd7;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge CLK); n++; end
        assertions++;
        if (resp_valid !== 1'b1 || resp_data !== ref_mem[0]) begin
            failures++;
            $display("FAIL midrst_beat0: valid=%b data=%h, required 1 %h", resp_valid, resp_data, ref_mem[0]);
        end
        @(posedge CLK); #1;
        n = 0;
        while (!RdEn && n < 20) begin @(negedge CLK); n++; end
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        assertions++;
        if (resp_valid !== 1'b0 || WrEn !== 1'b0 || RdEn !== 1'b0 || req_ready !== 1'b0 ||
            resp_data !== 16'h0 || resp_last !== 1'b0 || Address !== 4'h0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b WrEn=%b RdEn=%b ready=%b data=%h last=%b Addr=%h, required 0 0 0 0 0000 0 0",
                     resp_valid, WrEn, RdEn, req_ready, resp_data, resp_last, Address);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        assertions++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
        run_txn(1'b0, 4'd4, 16'h0000, 3'd0, -1, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 16'($urandom),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf[i]      = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        test_reset();
        test_write();
        test_single_read();
        test_wrap_burst();
        test_illegal();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1);
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Request/response front end that sits directly upstream of the 8 x 16-bit register file and is its only master. It accepts single writes and 1-8 beat read bursts over a valid/ready request channel. It drives the register file's WrData/Address/WrEn/RdEn strobes, captures RdData at the correct cycle, and returns one response beat per access over a valid/ready response channel.

## Interface
- DATA_W, 16: data width; matches register width.
- ADDR_W, 4: address bus width on both request and register-file sides.
- NUM_REGS, 8: implemented registers; any address >= NUM_REGS is illegal.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on a CLK edge where req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  base register address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- req_len  in  3  read burst length minus 1 (0 = 1 beat, 7 = 8 beats); ignored for writes.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  consumer accepts beat on edge with resp_valid && resp_ready.
- resp_data  out  DATA_W  read data; 0 for write acks and errors.
- resp_last  out  1  final beat of the transaction.
- resp_err  out  1  illegal base address; no register-file access was made.
- WrData  out  DATA_W  to register file.
- Address  out  ADDR_W  to register file.
- WrEn  out  1  write strobe.
- RdEn  out  1  read strobe.
- RdData  in  DATA_W  from register file. Registered there: valid in the cycle after the RdEn cycle.

## Operation
- Request fields are latched on acceptance. Internal state: base/current address, beat counter (3 bits), write data, and the op.
- FSM states: IDLE, WR, RD, CAPT, RESP, ERR.
- IDLE: req_ready=1. On accept:
  - req_addr >= NUM_REGS -> ERR.
  - else write -> WR.
  - else read -> RD, with beats_left = req_len.
- WR: one cycle. WrEn=1, Address=latched addr, WrData=latched data. Next state RESP with resp_data=0, resp_last=1.
- RD: one cycle. RdEn=1, Address=current addr. Next state CAPT.
- CAPT: one cycle, strobes low. resp_data <= RdData at the end of this cycle. resp_last <= (beats_left==0). Next state RESP.
- RESP: resp_valid=1. All outputs hold until resp_ready.
  - On handshake, if resp_last -> IDLE.
  - Otherwise current addr <= (addr+1) mod NUM_REGS, beats_left-1 -> RD.
- ERR: next state RESP with resp_err=1, resp_data=0, resp_last=1. WrEn/RdEn are never asserted for the illegal request.
- Invariants:
  - WrEn and RdEn are never high together.
  - Each strobe lasts exactly one cycle.
  - Address[ADDR_W-1:3] is always 0 while either strobe is high.
  - Register-file outputs are otherwise held at their last value. WrEn and RdEn are 0 outside WR/RD.
- Burst wrap: base 6, req_len 3 reads 6,7,0,1. Only the base address is range-checked.
- Writes are always single-beat acks. req_len has no effect on writes.

## Timing
- Reset values: req_ready=0 while RST high, then 1 (IDLE). resp_valid=0, resp_data=0, resp_last=0, resp_err=0, WrEn=0, RdEn=0, Address=0, WrData=0, FSM=IDLE, counters 0.
- RST asserted mid-transaction: outputs go to reset values immediately (asynchronously). Any in-flight response is discarded and the burst is abandoned.
- Write latency: accept at edge E. WrEn high in cycle E+1. resp_valid high from cycle E+2.
- Read latency: accept at edge E. RdEn in cycle E+1. RdData valid and captured in cycle E+2. resp_valid from cycle E+3.
- Each subsequent burst beat adds 3 cycles plus any resp_ready stall. With resp_ready tied high, an N-beat read completes in 3N cycles after acceptance.
- Back-to-back: req_ready rises in the cycle after the last response handshake, so there is a minimum 1 idle cycle between transactions.
- resp_ready held low: no register-file strobes are issued and no further reads are made until the handshake.

## Test plan
- Reset then write: write addr 3, data 0xA5A5 -> WrEn exactly 1 cycle with Address=3, WrData=0xA5A5. Ack beat: resp_data=0, resp_last=1, resp_err=0.
- Single read: write 0x1234 to addr 5, then read addr 5, len 0 -> RdEn 1 cycle. resp_data=0x1234, resp_last=1, resp_valid 3 cycles after acceptance.
- Wrapping burst: registers preloaded with 0x1000+i; read base 6, len 3 -> beats 0x1006, 0x1007, 0x1000, 0x1001, with resp_last only on the 4th beat.
- Illegal address: read addr 9, len 5 -> a single beat with resp_err=1, resp_data=0, resp_last=1. WrEn/RdEn stay 0 throughout.
- Backpressure: during an 8-beat burst, hold resp_ready low for 5 cycles on beat 3 -> resp_valid and resp_data stable, no RdEn pulses while stalled, all 8 beats are correct in order.
- Reset mid-burst: assert RST during CAPT of beat 2 -> resp_valid=0 and strobes=0 immediately. After release, req_ready=1 and a fresh single read returns correct data.
